// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional build macro: UART_TX_SCHED_CRLF_EN (append CR/LF after each completed message).
package uart_tx_sched_pkg;

    // Width of the grant index presented on grant_id.
    localparam int unsigned GID_W = 3;

`ifdef UART_TX_SCHED_CRLF_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK,
        ST_CR,
        ST_LF
    } state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
`else
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_LOCK
    } state_e;
`endif

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or above
// the pointer, wrapping modulo NUM_REQ.
// Optional build macro: UART_TX_SCHED_CRLF_EN (no effect in this file).
module uart_tx_rr_arb
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GID_W-1:0]   rr_ptr_i,
    output logic [GID_W-1:0]   win_o,
    output logic               any_o
);

    // Scan priority positions starting at the pointer; first hit wins.
    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!any_o && req_i[i] && (((32'(rr_ptr_i) + off) % NUM_REQ) == i)) begin
                    any_o = 1'b1;
                    win_o = GID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Message-granular round-robin scheduler in front of uart_tx, with a
// one-character output register and a per-message stall timeout.
// Optional build macro: UART_TX_SCHED_CRLF_EN (append CR/LF after each completed message).
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 3,
    parameter  int unsigned MSG_TIMEOUT = 1000,
    localparam int unsigned CW          = $clog2(MSG_TIMEOUT + 1)
) (
    input  logic                   clk_tx,
    input  logic                   rst_clk_tx_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_data_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_data_ready,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    state_e             state_q;
    logic [GID_W-1:0]   grant_q;
    logic [GID_W-1:0]   rr_q;
    logic [GID_W-1:0]   rr_d;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               txv_q;
    logic [7:0]         txd_q;
    logic               terr_q;

    logic               out_free;
    logic               sel_valid;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               xfer;
    logic               expire;
    logic [GID_W-1:0]   arb_win;
    logic               arb_any;

    uart_tx_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i    (req_valid),
        .rr_ptr_i (rr_q),
        .win_o    (arb_win),
        .any_o    (arb_any)
    );

    assign out_free = !txv_q || tx_data_ready;
    assign xfer     = (state_q == ST_LOCK) && sel_valid && out_free;
    assign expire   = (state_q == ST_LOCK) && !sel_valid && (cnt_q == CW'(MSG_TIMEOUT - 1));
    assign rr_d     = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + GID_W'(1);

    // Select the granted requester's valid/data/last.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
            end
        end
    end

    // Only the locked requester sees ready, and only when the output register can take a character.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if ((state_q == ST_LOCK) && out_free && (grant_q == GID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Scheduler FSM, timeout counter and output character register.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= 8'h00;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            // Drain first; a load below in the same cycle overrides this.
            if (txv_q && tx_data_ready) begin
                txv_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        state_q <= ST_LOCK;
                        grant_q <= arb_win;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_LOCK: begin
                    if (xfer) begin
                        txv_q <= 1'b1;
                        txd_q <= sel_data;
                        cnt_q <= '0;
                        if (sel_last) begin
                            rr_q <= rr_d;
`ifdef UART_TX_SCHED_CRLF_EN
                            state_q <= ST_CR;
`else
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
`endif
                        end
                    end else if (expire) begin
                        terr_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        rr_q    <= rr_d;
                    end else if (!sel_valid) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef UART_TX_SCHED_CRLF_EN
                ST_CR: begin
                    if (out_free) begin
                        txv_q   <= 1'b1;
                        txd_q   <= CHAR_CR;
                        state_q <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (out_free) begin
                        txv_q   <= 1'b1;
                        txd_q   <= CHAR_LF;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_data_valid = txv_q;
    assign tx_data       = txd_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed cases plus randomized
// message streams checked against a message-level round-robin model.
// Honours UART_TX_SCHED_CRLF_EN when it is defined for the build.
module tb_uart_tx_sched;

    localparam int unsigned N   = 3;
    localparam int unsigned TMO = 8;

    logic             clk_tx = 1'b0;
    logic             rst_clk_tx_n;
    logic [N-1:0]     req_valid;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_data_valid;
    logic [7:0]       tx_data;
    logic             tx_data_ready;
    logic [2:0]       grant_id;
    logic             busy;
    logic             timeout_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Pending characters per requester and the expected UART stream.
    logic [7:0]  rq_chr [N][$];
    bit          rq_lst [N][$];
    logic [7:0]  exp_q  [$];
    int unsigned m_rr = 0;

    uart_tx_sched #(
        .NUM_REQ     (N),
        .MSG_TIMEOUT (TMO)
    ) dut (
        .clk_tx        (clk_tx),
        .rst_clk_tx_n  (rst_clk_tx_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_tx);
    endtask

    task automatic set_req(input int unsigned r, input logic v, input logic [7:0] d, input logic l);
        req_valid[r]       = v;
        req_data[8*r +: 8] = d;
        req_last[r]        = l;
    endtask

    task automatic do_reset();
        rst_clk_tx_n  = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        tx_data_ready = 1'b1;
        for (int unsigned r = 0; r < N; r++) begin
            rq_chr[r].delete();
            rq_lst[r].delete();
        end
        exp_q.delete();
        m_rr = 0;
        repeat (2) tick();
        rst_clk_tx_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"},  busy,          0);
        chk({pfx, "_txv"},   tx_data_valid, 0);
        chk({pfx, "_txd"},   tx_data,       0);
        chk({pfx, "_gid"},   grant_id,      0);
        chk({pfx, "_terr"},  timeout_err,   0);
        chk({pfx, "_rdy"},   req_ready,     0);
    endtask

    task automatic add_msg(input int unsigned r, input int unsigned len, input bit rnd);
        for (int unsigned k = 0; k < len; k++) begin
            rq_chr[r].push_back(rnd ? 8'($urandom) : 8'(8'h10 * (r + 1) + k));
            rq_lst[r].push_back(k == len - 1);
        end
    endtask

    task automatic present(input int unsigned r, input bit hide);
        if (!hide && rq_chr[r].size() > 0) set_req(r, 1'b1, rq_chr[r][0], rq_lst[r][0]);
        else                               set_req(r, 1'b0, 8'h00, 1'b0);
    endtask

    // Drains all queued messages; entered and left at a drive point.
    task automatic run_stream(input int unsigned rdy_pct);
        int unsigned pos [N];
        int unsigned gap [N];
        logic [N-1:0] xf;
        bit           found, done, prev_hold;
        logic [7:0]   prev_dat;
        int unsigned  ptr, r, cyc;

        // Reference: whole messages, round-robin from the model pointer.
        ptr = m_rr;
        r   = 0;
        for (int unsigned i = 0; i < N; i++) pos[i] = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int unsigned off = 0; off < N && !found; off++) begin
                r = (ptr + off) % N;
                if (pos[r] < rq_chr[r].size()) found = 1'b1;
            end
            if (found) begin
                do begin
                    exp_q.push_back(rq_chr[r][pos[r]]);
                    done = rq_lst[r][pos[r]];
                    pos[r]++;
                end while (!done);
`ifdef UART_TX_SCHED_CRLF_EN
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
`endif
                ptr = (r + 1) % N;
            end
        end
        m_rr = ptr;

        for (int unsigned i = 0; i < N; i++) begin
            gap[i] = 0;
            present(i, 1'b0);
        end
        tx_data_ready = ($urandom_range(0, 99) < rdy_pct);
        prev_hold = 1'b0;
        prev_dat  = 8'h00;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            smp();
            if (prev_hold) chk("hold", {tx_data_valid, tx_data}, {1'b1, prev_dat});
            chk("terr_quiet", timeout_err, 0);
            chk("rdy_onehot", ($countones(req_ready) <= 1), 1);
            xf = req_valid & req_ready;
            for (int unsigned i = 0; i < N; i++) begin
                if (xf[i]) begin
                    chk("xfer_gid",  grant_id, i);
                    chk("xfer_busy", busy,     1);
                end
            end
            if (tx_data_valid && tx_data_ready) chk("stream", tx_data, exp_q.pop_front());
            prev_hold = tx_data_valid && !tx_data_ready;
            prev_dat  = tx_data;
            tick();
            for (int unsigned i = 0; i < N; i++) begin
                if (xf[i]) begin
                    done = rq_lst[i][0];
                    rq_lst[i].delete(0);
                    rq_chr[i].delete(0);
                    gap[i] = done ? 0 : $urandom_range(0, 3);
                end
                if (gap[i] > 0) begin
                    present(i, 1'b1);
                    gap[i]--;
                end else begin
                    present(i, 1'b0);
                end
            end
            tx_data_ready = ($urandom_range(0, 99) < rdy_pct);
            cyc++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_left", exp_q.size(), 0);
            exp_q.delete();
        end
        req_valid     = '0;
        tx_data_ready = 1'b1;
        smp();
        chk("end_busy", busy,          0);
        chk("end_txv",  tx_data_valid, 0);
        tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        smp();
        chk_reset_vals("rst");
        tick();

        // Single message "Hi": first character two cycles after valid
        set_req(0, 1'b1, 8'h48, 1'b0);
        smp();
        chk("t1_arb_busy", busy,          0);
        chk("t1_arb_rdy",  req_ready,     0);
        chk("t1_arb_txv",  tx_data_valid, 0);
        tick();
        smp();
        chk("t1_lock_busy", busy,      1);
        chk("t1_lock_gid",  grant_id,  0);
        chk("t1_lock_rdy",  req_ready, 3'b001);
        tick();
        set_req(0, 1'b1, 8'h69, 1'b1);
        smp();
        chk("t1_c0", {tx_data_valid, tx_data}, {1'b1, 8'h48});
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        smp();
        chk("t1_c1", {tx_data_valid, tx_data}, {1'b1, 8'h69});
`ifdef UART_TX_SCHED_CRLF_EN
        chk("t1_busy_cr", busy, 1);
        tick();
        smp();
        chk("t1_cr", {tx_data_valid, tx_data}, {1'b1, 8'h0D});
        chk("t1_busy_lf", busy, 1);
        tick();
        smp();
        chk("t1_lf", {tx_data_valid, tx_data}, {1'b1, 8'h0A});
        chk("t1_done_busy", busy, 0);
`else
        chk("t1_done_busy", busy, 0);
        tick();
        smp();
        chk("t1_drain", tx_data_valid, 0);
`endif
        tick();

        // Reset mid-message (pointer is 1 here); afterwards req0 must win over req1
        set_req(0, 1'b1, 8'h51, 1'b0);
        tick();
        tick();
        set_req(0, 1'b1, 8'h52, 1'b0);
        set_req(1, 1'b1, 8'h61, 1'b1);
        #1;
        rst_clk_tx_n = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        smp();
        rst_clk_tx_n = 1'b1;
        tick();
        smp();
        chk("t5_busy", busy,      1);
        chk("t5_gid",  grant_id,  0);
        chk("t5_rdy",  req_ready, 3'b001);
        tick();

        // Timeout: req1 stalls after one character, req2 waits
        do_reset();
        set_req(1, 1'b1, 8'h71, 1'b0);
        set_req(2, 1'b1, 8'h81, 1'b1);
        tick();
        smp();
        chk("t4_rdy", req_ready, 3'b010);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        for (int unsigned k = 0; k < TMO; k++) begin
            smp();
            chk("t4_wait_terr", timeout_err, 0);
            chk("t4_wait_busy", busy,        1);
            tick();
        end
        smp();
        chk("t4_terr", timeout_err, 1);
        chk("t4_idle", busy,        0);
        tick();
        smp();
        chk("t4_terr_pulse", timeout_err, 0);
        chk("t4_next_busy",  busy,        1);
        chk("t4_next_gid",   grant_id,    2);
        chk("t4_next_rdy",   req_ready,   3'b100);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        smp();
        chk("t4_char", {tx_data_valid, tx_data}, {1'b1, 8'h81});
        tick();

        // Backpressure for 10 cycles (longer than the timeout) mid-message
        do_reset();
        set_req(0, 1'b1, 8'h31, 1'b0);
        tick();
        tick();
        set_req(0, 1'b1, 8'h32, 1'b1);
        tx_data_ready = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            smp();
            chk("t3_hold", {tx_data_valid, tx_data}, {1'b1, 8'h31});
            chk("t3_rdy",  req_ready,   0);
            chk("t3_terr", timeout_err, 0);
            tick();
        end
        tx_data_ready = 1'b1;
        smp();
        chk("t3_resume_rdy", req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        smp();
        chk("t3_c1", {tx_data_valid, tx_data}, {1'b1, 8'h32});
        chk("t3_terr_end", timeout_err, 0);
        tick();

        // Contention: three 3-character messages, then again with the pointer at 1
        do_reset();
        for (int unsigned r = 0; r < N; r++) add_msg(r, 3, 1'b0);
        run_stream(100);
        add_msg(0, 1, 1'b0);
        run_stream(100);
        for (int unsigned r = 0; r < N; r++) add_msg(r, 3, 1'b0);
        run_stream(100);

        // Randomized message mixes with random backpressure and intra-message gaps
        do_reset();
        for (int unsigned round = 0; round < 8; round++) begin
            for (int unsigned r = 0; r < N; r++) begin
                int unsigned nm;
                nm = $urandom_range(0, 3);
                for (int unsigned m = 0; m < nm; m++) add_msg(r, $urandom_range(1, 4), 1'b1);
            end
            run_stream(70);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
